// File: rtl/oric_tap_writer.sv
// rtl/oric_tap_writer.sv - streams an Oric RAM range out as a .tap image (leader, header, name, data).
// Define TAP_LONG_LEADER_EN for a 16-byte 0x16 leader; otherwise the leader is 3 bytes.
module oric_tap_writer #(
  parameter int NAME_MAX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic        is_basic,
  input  logic        autorun,
  output logic [3:0]  name_idx,
  input  logic [7:0]  name_char,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_q,
  output logic [7:0]  tap_dout,
  output logic        tap_valid,
  input  logic        tap_ready,
  output logic [16:0] tap_count,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef TAP_LONG_LEADER_EN
  localparam int LEADER = 16;
`else
  localparam int LEADER = 3;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_HDR, S_NAME, S_NAMEZ, S_FETCH, S_WAIT, S_DATA, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  dout_q, dout_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  nidx_q, nidx_d;
  logic [16:0] ptr_q, ptr_d;
  logic [15:0] end_q, end_d;
  logic        type_q, type_d;
  logic        auto_q, auto_d;
  logic [16:0] count_q, count_d;
  logic        err_q, err_d;

  logic        accept, start_ok, name_end, last_data;
  logic [3:0]  cnt_inc;
  logic [7:0]  hdr_next;

  assign accept    = tap_valid & tap_ready;
  assign start_ok  = start & ~abort & (end_addr >= start_addr);
  assign cnt_inc   = cnt_q + 4'd1;
  assign last_data = (ptr_q == {1'b0, end_q});
  // nidx_q already points at the next character, so name_char is the one to load on accept.
  assign name_end  = (name_char == 8'h00) || (nidx_q == 5'(NAME_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dout_q  <= 8'h00;
      cnt_q   <= 4'd0;
      nidx_q  <= 5'd0;
      ptr_q   <= 17'd0;
      end_q   <= 16'd0;
      type_q  <= 1'b0;
      auto_q  <= 1'b0;
      count_q <= 17'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      nidx_q  <= nidx_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      type_q  <= type_d;
      auto_q  <= auto_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = S_SYNC;
        S_SYNC:  if (accept && cnt_q == 4'(LEADER - 1)) state_d = S_HDR;
        S_HDR:   if (accept && cnt_q == 4'd9) state_d = name_end ? S_NAMEZ : S_NAME;
        S_NAME:  if (accept && name_end) state_d = S_NAMEZ;
        S_NAMEZ: if (accept) state_d = S_FETCH;
        S_FETCH: state_d = S_WAIT;
        S_WAIT:  state_d = S_DATA;
        S_DATA:  if (accept) state_d = last_data ? S_DONE : S_FETCH;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hdr_next = 8'h00;
    case (cnt_inc)
      4'd3:    hdr_next = {type_q, 7'b0};
      4'd4:    hdr_next = auto_q ? 8'hC7 : 8'h00;
      4'd5:    hdr_next = end_q[15:8];
      4'd6:    hdr_next = end_q[7:0];
      4'd7:    hdr_next = ptr_q[15:8];
      4'd8:    hdr_next = ptr_q[7:0];
      default: hdr_next = 8'h00;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    nidx_d  = nidx_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    type_d  = type_q;
    auto_d  = auto_q;
    count_d = accept ? count_q + 17'd1 : count_q;
    err_d   = (state_q == S_IDLE) && start && !abort && (end_addr < start_addr);
    if (!(state_q != S_IDLE && abort)) begin
      case (state_q)
        S_IDLE: if (start_ok) begin
          ptr_d   = {1'b0, start_addr};
          end_d   = end_addr;
          type_d  = ~is_basic;
          auto_d  = autorun;
          dout_d  = 8'h16;
          cnt_d   = 4'd0;
          nidx_d  = 5'd0;
          count_d = 17'd0;
        end
        S_SYNC: if (accept) begin
          if (cnt_q == 4'(LEADER - 1)) begin
            dout_d = 8'h24;
            cnt_d  = 4'd0;
          end else begin
            cnt_d  = cnt_inc;
          end
        end
        S_HDR: if (accept) begin
          if (cnt_q == 4'd9) begin
            dout_d = name_end ? 8'h00 : name_char;
            nidx_d = name_end ? nidx_q : nidx_q + 5'd1;
          end else begin
            dout_d = hdr_next;
            cnt_d  = cnt_inc;
          end
        end
        S_NAME: if (accept) begin
          dout_d = name_end ? 8'h00 : name_char;
          nidx_d = name_end ? nidx_q : nidx_q + 5'd1;
        end
        S_WAIT: dout_d = ram_q;
        S_DATA: if (accept && !last_data) ptr_d = ptr_q + 17'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    tap_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    ram_rd    = 1'b0;
    case (state_q)
      S_SYNC, S_HDR, S_NAME, S_NAMEZ, S_DATA: tap_valid = 1'b1;
      S_FETCH: ram_rd = 1'b1;
      S_IDLE:  busy = 1'b0;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      default: ;
    endcase
  end

  assign tap_dout  = dout_q;
  assign tap_count = count_q;
  assign ram_addr  = ptr_q[15:0];
  assign name_idx  = nidx_q[3:0];
  assign err       = err_q;

endmodule
